// File: rtl/mod_4051_pkg.sv
// Shared constants and types for the mod-4051 residue reducer stages.
package mod_4051_pkg;

  localparam int unsigned MODULUS    = 4051;
  localparam int unsigned RES_W      = 12;
  localparam int unsigned MAX_CHUNKS = 84;
  localparam int unsigned CNT_W      = 7;

  typedef logic [RES_W-1:0] residue_t;

  typedef enum logic {
    ACCUM,
    HOLD
  } acc_state_t;

endpackage

// File: rtl/mod_add.sv
// Combinational modular adder: s = (a + b) mod MODULUS for a, b < MODULUS.
// One conditional subtract is enough because a + b <= 2*MODULUS - 2.
module mod_add #(
  parameter int unsigned MODULUS = mod_4051_pkg::MODULUS,
  parameter int unsigned W       = mod_4051_pkg::RES_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] s
);
  import mod_4051_pkg::*;

  localparam logic [W:0] ModWide = (W+1)'(MODULUS);

  logic [W:0] sum;
  logic [W:0] diff;

  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    diff = sum - ModWide;
    s    = (sum >= ModWide) ? diff[W-1:0] : sum[W-1:0];
  end

endmodule

// File: rtl/mod_residue_accum.sv
// Frame-based modular accumulator of per-chunk partial residues over a valid/ready stream.
// Optional input range checking with out_err is enabled by defining MOD_RESIDUE_RANGE_CHECK_EN.
module mod_residue_accum #(
  parameter int unsigned MODULUS    = mod_4051_pkg::MODULUS,
  parameter int unsigned W          = mod_4051_pkg::RES_W,
  parameter int unsigned MAX_CHUNKS = mod_4051_pkg::MAX_CHUNKS,
  parameter int unsigned CNT_W      = mod_4051_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_residue,
  output logic [CNT_W-1:0] out_chunks
`ifdef MOD_RESIDUE_RANGE_CHECK_EN
  ,
  output logic             out_err
`endif
);
  import mod_4051_pkg::*;

  localparam logic [W-1:0]     ModW     = W'(MODULUS);
  localparam logic [CNT_W-1:0] MaxCnt   = CNT_W'(MAX_CHUNKS);

  acc_state_t       state_q, state_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     res_q, res_d;
  logic [CNT_W-1:0] chunks_q, chunks_d;
  // Holds in_ready low until the first clock edge after reset releases.
  logic             started_q;

  logic [W-1:0]     sum_mod;
  logic [W-1:0]     acc_next;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;
  logic             term_beat;

  mod_add #(
    .MODULUS(MODULUS),
    .W      (W)
  ) u_mod_add (
    .a(acc_q),
    .b(in_data),
    .s(sum_mod)
  );

`ifdef MOD_RESIDUE_RANGE_CHECK_EN
  logic err_q, err_d;
  logic oerr_q, oerr_d;
  logic beat_err;

  // Out-of-range input can leave one extra MODULUS after the first subtract.
  always_comb begin
    beat_err = (in_data >= ModW);
    acc_next = (sum_mod >= ModW) ? (sum_mod - ModW) : sum_mod;
  end

  assign out_err = oerr_q;
`else
  assign acc_next = sum_mod;
`endif

  assign cnt_inc     = cnt_q + 1'b1;
  assign accept      = in_valid && in_ready;
  assign term_beat   = in_last || (cnt_inc == MaxCnt);
  assign out_residue = res_q;
  assign out_chunks  = chunks_q;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    chunks_d  = chunks_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
`ifdef MOD_RESIDUE_RANGE_CHECK_EN
    err_d     = err_q;
    oerr_d    = oerr_q;
`endif
    unique case (state_q)
      ACCUM: begin
        in_ready = started_q;
        if (accept) begin
          acc_d = acc_next;
          cnt_d = cnt_inc;
`ifdef MOD_RESIDUE_RANGE_CHECK_EN
          err_d = err_q | beat_err;
`endif
          if (term_beat) begin
            res_d    = acc_next;
            chunks_d = cnt_inc;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = HOLD;
`ifdef MOD_RESIDUE_RANGE_CHECK_EN
            oerr_d   = err_q | beat_err;
            err_d    = 1'b0;
`endif
          end
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ACCUM;
`ifdef MOD_RESIDUE_RANGE_CHECK_EN
          oerr_d  = 1'b0;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      cnt_q     <= '0;
      res_q     <= '0;
      chunks_q  <= '0;
      started_q <= 1'b0;
`ifdef MOD_RESIDUE_RANGE_CHECK_EN
      err_q     <= 1'b0;
      oerr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      chunks_q  <= chunks_d;
      started_q <= 1'b1;
`ifdef MOD_RESIDUE_RANGE_CHECK_EN
      err_q     <= err_d;
      oerr_q    <= oerr_d;
`endif
    end
  end

endmodule

// File: tb/tb_mod_residue_accum.sv
// Self-checking bench for mod_residue_accum: scoreboard of expected frame results.
// Exercises the MOD_RESIDUE_RANGE_CHECK_EN feature when that macro is defined.
module tb_mod_residue_accum;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] out_residue;
  logic [6:0]  out_chunks;
`ifdef MOD_RESIDUE_RANGE_CHECK_EN
  logic        out_err;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [11:0] res;
    logic [6:0]  chunks;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  mod_residue_accum dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_residue(out_residue),
    .out_chunks (out_chunks)
`ifdef MOD_RESIDUE_RANGE_CHECK_EN
    ,
    .out_err    (out_err)
`endif
  );

  // Scoreboard monitor: every consumed result must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_result: got residue %0d chunks %0d, required no result",
                 out_residue, out_chunks);
      end else begin
        n_pass++;
        mon_e = sb.pop_front();
        n_checks++;
        if (out_residue !== mon_e.res)
          $display("FAIL residue: got %0d, required %0d", out_residue, mon_e.res);
        else n_pass++;
        n_checks++;
        if (out_chunks !== mon_e.chunks)
          $display("FAIL chunks: got %0d, required %0d", out_chunks, mon_e.chunks);
        else n_pass++;
`ifdef MOD_RESIDUE_RANGE_CHECK_EN
        n_checks++;
        if (out_err !== mon_e.err)
          $display("FAIL out_err: got %0b, required %0b", out_err, mon_e.err);
        else n_pass++;
`endif
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Present one beat and wait (bounded) for the handshake edge; returns at edge + 1.
  task automatic drive_beat(input logic [11:0] d, input logic l, output bit ok);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    ok       = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Wait (bounded) for out_valid, then accept the result for one cycle.
  task automatic consume(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (out_valid) ok = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (ok) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %0b, required 0", in_ready);
    else n_pass++;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b, required 0", out_valid);
    else n_pass++;
    n_checks++;
    if (out_residue !== 12'd0) $display("FAIL reset_residue: got %0d, required 0", out_residue);
    else n_pass++;
    n_checks++;
    if (out_chunks !== 7'd0) $display("FAIL reset_chunks: got %0d, required 0", out_chunks);
    else n_pass++;
`ifdef MOD_RESIDUE_RANGE_CHECK_EN
    n_checks++;
    if (out_err !== 1'b0) $display("FAIL reset_out_err: got %0b, required 0", out_err);
    else n_pass++;
`endif
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b0)
      $display("FAIL ready_before_edge: got %0b, required 0", in_ready);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL ready_after_edge: got %0b, required 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_basic();
    bit ok, all_ok;
    all_ok = 1'b1;
    sb.push_back('{res: 12'd600, chunks: 7'd3, err: 1'b0});
    drive_beat(12'd100, 1'b0, ok); all_ok &= ok;
    drive_beat(12'd200, 1'b0, ok); all_ok &= ok;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL basic_early_valid: got %0b, required 0", out_valid);
    else n_pass++;
    drive_beat(12'd300, 1'b1, ok); all_ok &= ok;
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL basic_latency: got %0b, required 1", out_valid);
    else n_pass++;
    n_checks++;
    if (!all_ok) $display("FAIL basic_accept: got timeout, required handshake");
    else n_pass++;
    consume(ok);
    n_checks++;
    if (!ok) $display("FAIL basic_result: got timeout, required out_valid");
    else n_pass++;
  endtask

  task automatic test_wrap();
    bit ok, all_ok;
    all_ok = 1'b1;
    sb.push_back('{res: 12'd0, chunks: 7'd2, err: 1'b0});
    drive_beat(12'd4050, 1'b0, ok); all_ok &= ok;
    drive_beat(12'd1, 1'b1, ok); all_ok &= ok;
    consume(ok); all_ok &= ok;
    sb.push_back('{res: 12'd4049, chunks: 7'd2, err: 1'b0});
    drive_beat(12'd4050, 1'b0, ok); all_ok &= ok;
    drive_beat(12'd4050, 1'b1, ok); all_ok &= ok;
    consume(ok); all_ok &= ok;
    n_checks++;
    if (!all_ok) $display("FAIL wrap_flow: got timeout, required completion");
    else n_pass++;
  endtask

  task automatic test_max_chunks();
    bit ok, all_ok;
    all_ok = 1'b1;
    sb.push_back('{res: 12'd1241, chunks: 7'd84, err: 1'b0});
    for (int i = 0; i < 83; i++) begin
      drive_beat(12'd63, 1'b0, ok);
      all_ok &= ok;
    end
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL max_early_valid: got %0b, required 0", out_valid);
    else n_pass++;
    drive_beat(12'd63, 1'b0, ok); all_ok &= ok;
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL max_forced_term: got %0b, required 1", out_valid);
    else n_pass++;
    consume(ok); all_ok &= ok;
    n_checks++;
    if (!all_ok) $display("FAIL max_flow: got timeout, required completion");
    else n_pass++;
  endtask

  task automatic test_last_at_boundary();
    bit ok, all_ok;
    all_ok = 1'b1;
    // 84 * 100 = 8400, and 8400 - 2*4051 = 298.
    sb.push_back('{res: 12'd298, chunks: 7'd84, err: 1'b0});
    for (int i = 0; i < 84; i++) begin
      drive_beat(12'd100, (i == 83), ok);
      all_ok &= ok;
    end
    consume(ok); all_ok &= ok;
    n_checks++;
    if (!all_ok) $display("FAIL boundary_flow: got timeout, required completion");
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL boundary_double: got %0b, required 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit ok, all_ok;
    all_ok = 1'b1;
    sb.push_back('{res: 12'd11, chunks: 7'd1, err: 1'b0});
    drive_beat(12'd11, 1'b1, ok); all_ok &= ok;
    in_valid = 1'b1;
    in_data  = 12'd7;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0) $display("FAIL hold_ready[%0d]: got %0b, required 0", i, in_ready);
      else n_pass++;
      n_checks++;
      if (out_valid !== 1'b1) $display("FAIL hold_valid[%0d]: got %0b, required 1", i, out_valid);
      else n_pass++;
      n_checks++;
      if (out_residue !== 12'd11)
        $display("FAIL hold_residue[%0d]: got %0d, required 11", i, out_residue);
      else n_pass++;
      n_checks++;
      if (out_chunks !== 7'd1)
        $display("FAIL hold_chunks[%0d]: got %0d, required 1", i, out_chunks);
      else n_pass++;
    end
    sb.push_back('{res: 12'd7, chunks: 7'd1, err: 1'b0});
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL resume_ready: got %0b, required 1", in_ready);
    else n_pass++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL frame2_valid: got %0b, required 1", out_valid);
    else n_pass++;
    consume(ok); all_ok &= ok;
    n_checks++;
    if (!all_ok) $display("FAIL b2b_flow: got timeout, required completion");
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    bit ok, all_ok;
    all_ok = 1'b1;
    drive_beat(12'd1000, 1'b0, ok); all_ok &= ok;
    drive_beat(12'd1000, 1'b0, ok); all_ok &= ok;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL midrst_ready: got %0b, required 0", in_ready);
    else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    sb.push_back('{res: 12'd5, chunks: 7'd1, err: 1'b0});
    drive_beat(12'd5, 1'b1, ok); all_ok &= ok;
    consume(ok); all_ok &= ok;
    // A pending, unconsumed result must vanish on reset.
    drive_beat(12'd9, 1'b1, ok); all_ok &= ok;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL drop_valid: got %0b, required 0", out_valid);
    else n_pass++;
    n_checks++;
    if (out_chunks !== 7'd0) $display("FAIL drop_chunks: got %0d, required 0", out_chunks);
    else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (!all_ok) $display("FAIL midrst_flow: got timeout, required completion");
    else n_pass++;
  endtask

`ifdef MOD_RESIDUE_RANGE_CHECK_EN
  task automatic test_range_check();
    bit ok, all_ok;
    all_ok = 1'b1;
    sb.push_back('{res: 12'd44, chunks: 7'd1, err: 1'b1});
    drive_beat(12'd4095, 1'b1, ok); all_ok &= ok;
    consume(ok); all_ok &= ok;
    sb.push_back('{res: 12'd10, chunks: 7'd1, err: 1'b0});
    drive_beat(12'd10, 1'b1, ok); all_ok &= ok;
    consume(ok); all_ok &= ok;
    n_checks++;
    if (!all_ok) $display("FAIL range_flow: got timeout, required completion");
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_max_chunks();
    test_last_at_boundary();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef MOD_RESIDUE_RANGE_CHECK_EN
    test_range_check();
`endif
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
